debug_ctrl: RTL and testbench
=============================

Name: debug_ctrl

Overview:
Host-driven debug controller; the write/control direction of the pipeline debug interface, complementing the read-only signal-capture port. Accepts host commands over a valid/ready channel (halt, resume, single-step, PC breakpoint, register write injection) and drives the pipeline freeze and register-file write override. It returns exactly one response per command. Sits beside the top-level pipeline: IF PC in, global stall and writeback override out.

Parameters:
STEP_W, 16, width of step counter; max step count 2^STEP_W-1
HALT_ON_RESET, 0, 1 = leave reset in HALTED, 0 = leave reset in RUN

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  reset, asynchronous, active-low
cmd_valid  in  1  host command valid
cmd_ready  out  1  controller can accept command
cmd_op  in  3  opcode: 0 NOP, 1 HALT, 2 RESUME, 3 STEP, 4 SET_BP, 5 CLR_BP, 6 WRITE_REG, 7 reserved
cmd_reg  in  5  register index for WRITE_REG
cmd_arg  in  32  step count / BP address / write data
rsp_valid  out  1  response valid, held until accepted
rsp_ready  in  1  host accepts response
rsp_err  out  1  1 = command rejected
rsp_data  out  32  response payload
pc_f  in  32  IF-stage PC
pc_valid  in  1  pc_f is a real fetch this cycle
stall  out  1  freeze all pipeline registers and PC
halted  out  1  state == HALTED
bp_hit  out  1  one-cycle pulse on breakpoint halt
dbg_we  out  1  register-file write override strobe
dbg_waddr  out  5  override write address
dbg_wdata  out  32  override write data

Behaviour:
- States: RUN, HALTED, STEPPING. stall = (state == HALTED). halted = (state == HALTED).
- Reset (async, rst_n low): state = HALTED if HALT_ON_RESET, else RUN; rsp_valid/rsp_err/rsp_data/bp_hit/dbg_we/dbg_waddr/dbg_wdata = 0; bp_en = 0; bp_addr = 0; step_cnt = 0; skip = 0. Reset mid-step or mid-response discards all pending activity.
- cmd_ready = !rsp_valid && state != STEPPING. Accept = cmd_valid && cmd_ready at cycle T.
- Responses: rsp_valid rises at T+1 unless stated otherwise; held with stable rsp_err/rsp_data until rsp_valid && rsp_ready; drops the cycle after that handshake.
- NOP: rsp_data = {31'b0, halted}.
- HALT:
  - RUN: state becomes HALTED at T+1; rsp_data = pc_f sampled at T.
  - Already HALTED: OK, rsp_data = pc_f.
- RESUME:
  - HALTED: state becomes RUN at T+1; skip = 1.
  - RUN: OK no-op.
  - rsp_data = 0.
- STEP:
  - Requires HALTED and cmd_arg[STEP_W-1:0] != 0, else rsp_err = 1.
  - Otherwise: state = STEPPING with stall low for exactly N cycles (T+1..T+N), then HALTED at T+N+1; skip = 1 at entry.
  - Response at T+N+1 with rsp_data = cycles executed (N).
  - Upper cmd_arg bits are ignored.
- SET_BP: bp_addr = cmd_arg, bp_en = 1. CLR_BP: bp_en = 0. Both are OK in any state; rsp_data = 0.
- WRITE_REG:
  - Requires HALTED and cmd_reg != 0, else rsp_err = 1 and no write.
  - Otherwise: dbg_we = 1 for exactly cycle T+1 with dbg_waddr = cmd_reg, dbg_wdata = cmd_arg.
  - rsp_data = cmd_arg.
- Reserved op 7: rsp_err = 1, no effect.
- Breakpoint:
  - Match = bp_en && pc_valid && pc_f == bp_addr && !skip, evaluated in RUN or STEPPING.
  - On match at cycle C: state = HALTED at C+1; bp_hit = 1 for cycle C+1 only.
  - Match during STEPPING ends the step early; step response at C+1 with rsp_data = cycles executed (including C).
- skip clears after the first cycle with pc_valid = 1 following RESUME/STEP entry, so resuming at a breakpoint PC does not re-trigger.
- Simultaneous HALT accept and match at T: HALTED at T+1, bp_hit pulses, HALT response OK with rsp_data = pc_f.
- No command changes state while rsp_valid is high: commands are blocked by cmd_ready.

Test Plan:
- Reset with HALT_ON_RESET=0 -> stall=0, rsp_valid=0; NOP -> rsp_data=0. HALT at pc_f=0x00400010 -> stall=1 next cycle, rsp_data=0x00400010.
- Halted, STEP arg=3 -> stall low exactly 3 cycles, cmd_ready=0 meanwhile, then stall=1, rsp_data=3, rsp_err=0. STEP arg=0 -> rsp_err=1, stall stays 1.
- SET_BP 0x00400020, run until pc_f=0x00400020 -> HALTED next cycle, one-cycle bp_hit. RESUME with pc_f still 0x00400020 -> no re-halt, PC advances.
- Halted, WRITE_REG reg=8 arg=0xDEADBEEF -> dbg_we=1 one cycle, waddr=8, wdata=0xDEADBEEF. reg=0 -> rsp_err=1, dbg_we stays 0. WRITE_REG in RUN -> rsp_err=1.
- Hold rsp_ready=0 for 5 cycles after HALT -> rsp_valid and rsp_data stable, cmd_ready=0, new cmd_valid ignored. After handshake, cmd_ready=1.
- STEP arg=10 with breakpoint reached on 4th stepped cycle -> HALTED early, bp_hit pulse, rsp_data=4. Assert rst_n=0 mid-step -> immediate RUN, rsp_valid=0, bp_en=0.

Source files
------------

// File: rtl/debug_ctrl.sv
// debug_ctrl: host-driven pipeline debug controller.
// Accepts halt / resume / single-step / breakpoint / register-inject commands
// over a valid/ready channel, freezes the pipeline and overrides the
// register-file write port, and returns exactly one response per command.
module debug_ctrl #(
    parameter int STEP_W        = 16,
    parameter bit HALT_ON_RESET = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [2:0]  cmd_op,
    input  logic [4:0]  cmd_reg,
    input  logic [31:0] cmd_arg,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_err,
    output logic [31:0] rsp_data,
    input  logic [31:0] pc_f,
    input  logic        pc_valid,
    output logic        stall,
    output logic        halted,
    output logic        bp_hit,
    output logic        dbg_we,
    output logic [4:0]  dbg_waddr,
    output logic [31:0] dbg_wdata
);
    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_HALTED   = 2'd1,
        ST_STEPPING = 2'd2
    } state_t;

    localparam state_t RESET_STATE = HALT_ON_RESET ? ST_HALTED : ST_RUN;

    localparam logic [2:0] OP_NOP    = 3'd0;
    localparam logic [2:0] OP_HALT   = 3'd1;
    localparam logic [2:0] OP_RESUME = 3'd2;
    localparam logic [2:0] OP_STEP   = 3'd3;
    localparam logic [2:0] OP_SET_BP = 3'd4;
    localparam logic [2:0] OP_CLR_BP = 3'd5;
    localparam logic [2:0] OP_WR_REG = 3'd6;

    localparam logic [STEP_W-1:0] STEP_ZERO = '0;
    localparam logic [STEP_W-1:0] STEP_ONE  = STEP_W'(1'b1);

    state_t              state_r;
    logic                rsp_valid_r;
    logic                rsp_err_r;
    logic [31:0]         rsp_data_r;
    logic                bp_hit_r;
    logic                dbg_we_r;
    logic [4:0]          dbg_waddr_r;
    logic [31:0]         dbg_wdata_r;
    logic                bp_en_r;
    logic [31:0]         bp_addr_r;
    logic [STEP_W-1:0]   step_cnt_r;   // cycles executed in the current step
    logic [STEP_W-1:0]   step_tgt_r;   // cycles requested by the host
    logic                skip_r;       // suppress the breakpoint on the first fetch after leaving HALTED

    logic                accept_s;
    logic                is_halted_s;
    logic                bp_match_s;
    logic [STEP_W-1:0]   step_arg_s;
    logic [STEP_W-1:0]   step_next_s;

    // Command handshake, breakpoint comparison and step-progress decode
    always_comb begin
        is_halted_s = (state_r == ST_HALTED);
        accept_s    = cmd_valid && !rsp_valid_r && (state_r != ST_STEPPING);
        step_arg_s  = cmd_arg[STEP_W-1:0];
        step_next_s = step_cnt_r + STEP_ONE;
        if (state_r != ST_HALTED) begin
            bp_match_s = bp_en_r && pc_valid && (pc_f == bp_addr_r) && !skip_r;
        end else begin
            bp_match_s = 1'b0;
        end
    end

    // Controller state, breakpoint, step progress and response registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= RESET_STATE;
            rsp_valid_r <= 1'b0;
            rsp_err_r   <= 1'b0;
            rsp_data_r  <= 32'd0;
            bp_hit_r    <= 1'b0;
            dbg_we_r    <= 1'b0;
            dbg_waddr_r <= 5'd0;
            dbg_wdata_r <= 32'd0;
            bp_en_r     <= 1'b0;
            bp_addr_r   <= 32'd0;
            step_cnt_r  <= STEP_ZERO;
            step_tgt_r  <= STEP_ZERO;
            skip_r      <= 1'b0;
        end else begin
            bp_hit_r <= 1'b0;
            dbg_we_r <= 1'b0;

            if (rsp_valid_r && rsp_ready) begin
                rsp_valid_r <= 1'b0;
            end

            if (skip_r && pc_valid && (state_r != ST_HALTED)) begin
                skip_r <= 1'b0;
            end

            // A step ends on its last requested cycle or on a breakpoint;
            // either way the cycle just executed is counted.
            if (state_r == ST_STEPPING) begin
                step_cnt_r <= step_next_s;
                if (bp_match_s || (step_next_s == step_tgt_r)) begin
                    state_r     <= ST_HALTED;
                    rsp_valid_r <= 1'b1;
                    rsp_err_r   <= 1'b0;
                    rsp_data_r  <= 32'(step_next_s);
                end
            end

            if (bp_match_s) begin
                state_r  <= ST_HALTED;
                bp_hit_r <= 1'b1;
            end

            if (accept_s) begin
                rsp_valid_r <= 1'b1;
                rsp_err_r   <= 1'b0;
                rsp_data_r  <= 32'd0;
                case (cmd_op)
                    OP_NOP: begin
                        rsp_data_r <= {31'd0, is_halted_s};
                    end
                    OP_HALT: begin
                        state_r    <= ST_HALTED;
                        rsp_data_r <= pc_f;
                    end
                    OP_RESUME: begin
                        if (is_halted_s) begin
                            state_r <= ST_RUN;
                            skip_r  <= 1'b1;
                        end
                    end
                    OP_STEP: begin
                        if (is_halted_s && (step_arg_s != STEP_ZERO)) begin
                            state_r     <= ST_STEPPING;
                            skip_r      <= 1'b1;
                            step_cnt_r  <= STEP_ZERO;
                            step_tgt_r  <= step_arg_s;
                            rsp_valid_r <= 1'b0;   // response comes when the step finishes
                        end else begin
                            rsp_err_r <= 1'b1;
                        end
                    end
                    OP_SET_BP: begin
                        bp_en_r   <= 1'b1;
                        bp_addr_r <= cmd_arg;
                    end
                    OP_CLR_BP: begin
                        bp_en_r <= 1'b0;
                    end
                    OP_WR_REG: begin
                        if (is_halted_s && (cmd_reg != 5'd0)) begin
                            dbg_we_r    <= 1'b1;
                            dbg_waddr_r <= cmd_reg;
                            dbg_wdata_r <= cmd_arg;
                            rsp_data_r  <= cmd_arg;
                        end else begin
                            rsp_err_r <= 1'b1;
                        end
                    end
                    default: begin
                        rsp_err_r <= 1'b1;
                    end
                endcase
            end
        end
    end

    assign cmd_ready = !rsp_valid_r && (state_r != ST_STEPPING);
    assign stall     = (state_r == ST_HALTED);
    assign halted    = (state_r == ST_HALTED);
    assign rsp_valid = rsp_valid_r;
    assign rsp_err   = rsp_err_r;
    assign rsp_data  = rsp_data_r;
    assign bp_hit    = bp_hit_r;
    assign dbg_we    = dbg_we_r;
    assign dbg_waddr = dbg_waddr_r;
    assign dbg_wdata = dbg_wdata_r;

endmodule

// File: tb/tb_debug_ctrl.sv
// tb_debug_ctrl: vector table, directed multi-cycle sequences and a
// randomized command stream checked against a transaction-level model.
module tb_debug_ctrl;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [2:0]  cmd_op;
    logic [4:0]  cmd_reg;
    logic [31:0] cmd_arg;
    logic        rsp_valid;
    logic        rsp_ready;
    logic        rsp_err;
    logic [31:0] rsp_data;
    logic [31:0] pc_f;
    logic        pc_valid;
    logic        stall;
    logic        halted;
    logic        bp_hit;
    logic        dbg_we;
    logic [4:0]  dbg_waddr;
    logic [31:0] dbg_wdata;

    debug_ctrl #(.STEP_W(16), .HALT_ON_RESET(1'b0)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_reg(cmd_reg), .cmd_arg(cmd_arg),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_err(rsp_err),
        .rsp_data(rsp_data), .pc_f(pc_f), .pc_valid(pc_valid),
        .stall(stall), .halted(halted), .bp_hit(bp_hit),
        .dbg_we(dbg_we), .dbg_waddr(dbg_waddr), .dbg_wdata(dbg_wdata)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Transaction-level model of the controller's visible state
    bit          m_halted;
    bit          m_bp_en;
    logic [31:0] m_bp_addr;
    bit          m_skip;

    typedef struct {
        logic [2:0]  op;
        logic [4:0]  r;
        logic [31:0] arg;
        logic [31:0] pc;
        logic        err;
        logic [31:0] data;
        logic        halted_after;
        logic        we;
    } vec_t;

    localparam int NV = 19;
    vec_t vt [NV];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [2:0] op, input logic [4:0] r, input logic [31:0] a);
        chk("cmd_ready_before_send", {31'd0, cmd_ready}, 32'd1);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_reg   = r;
        cmd_arg   = a;
        cyc();
        cmd_valid = 1'b0;
    endtask

    task automatic ack();
        rsp_ready = 1'b1;
        cyc();
        rsp_ready = 1'b0;
        chk("rsp_drop_after_ack", {31'd0, rsp_valid}, 32'd0);
    endtask

    function automatic logic [31:0] pool_pc();
        return 32'h0000_0100 + 32'($urandom_range(0, 3)) * 32'd4;
    endfunction

    // One random fetch cycle; the model halts on a breakpoint or when the
    // cycle is the last one of a step.
    task automatic run_cycle(input bit last, output bit hit);
        logic        v;
        logic [31:0] p;
        v    = ($urandom_range(0, 1) == 1);
        p    = pool_pc();
        hit  = 1'b0;
        pc_valid = v;
        pc_f     = p;
        if (!m_halted && v) begin
            if (m_bp_en && (p == m_bp_addr) && !m_skip) hit = 1'b1;
            m_skip = 1'b0;
        end
        cyc();
        if (!m_halted && (hit || last)) m_halted = 1'b1;
        chk("rand_bp_hit", {31'd0, bp_hit}, {31'd0, hit});
        chk("rand_halted", {31'd0, halted}, {31'd0, m_halted});
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog_timeout actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0]  op;
        logic [4:0]  r;
        logic [31:0] arg;
        logic [31:0] cmd_pc;
        logic        exp_err;
        logic [31:0] exp_data;
        logic        exp_we;
        logic [15:0] n;
        bit          hit;
        int          len;
        int          steps;
        int          dly;

        vt[0]  = '{3'd0, 5'd0,  32'h0000_0000, 32'h0040_0000, 1'b0, 32'h0000_0000, 1'b0, 1'b0};
        vt[1]  = '{3'd1, 5'd0,  32'h0000_0000, 32'h0040_0010, 1'b0, 32'h0040_0010, 1'b1, 1'b0};
        vt[2]  = '{3'd0, 5'd0,  32'h0000_0000, 32'h0040_0010, 1'b0, 32'h0000_0001, 1'b1, 1'b0};
        vt[3]  = '{3'd1, 5'd0,  32'h0000_0000, 32'h0040_0014, 1'b0, 32'h0040_0014, 1'b1, 1'b0};
        vt[4]  = '{3'd3, 5'd0,  32'h0000_0000, 32'h0040_0014, 1'b1, 32'h0000_0000, 1'b1, 1'b0};
        vt[5]  = '{3'd3, 5'd0,  32'h0001_0000, 32'h0040_0014, 1'b1, 32'h0000_0000, 1'b1, 1'b0};
        vt[6]  = '{3'd6, 5'd8,  32'hDEAD_BEEF, 32'h0040_0014, 1'b0, 32'hDEAD_BEEF, 1'b1, 1'b1};
        vt[7]  = '{3'd6, 5'd0,  32'h1234_5678, 32'h0040_0014, 1'b1, 32'h0000_0000, 1'b1, 1'b0};
        vt[8]  = '{3'd7, 5'd4,  32'h0000_0055, 32'h0040_0014, 1'b1, 32'h0000_0000, 1'b1, 1'b0};
        vt[9]  = '{3'd4, 5'd0,  32'h0040_0100, 32'h0040_0014, 1'b0, 32'h0000_0000, 1'b1, 1'b0};
        vt[10] = '{3'd5, 5'd0,  32'h0000_0000, 32'h0040_0014, 1'b0, 32'h0000_0000, 1'b1, 1'b0};
        vt[11] = '{3'd2, 5'd0,  32'h0000_0000, 32'h0040_0014, 1'b0, 32'h0000_0000, 1'b0, 1'b0};
        vt[12] = '{3'd2, 5'd0,  32'h0000_0000, 32'h0040_0014, 1'b0, 32'h0000_0000, 1'b0, 1'b0};
        vt[13] = '{3'd6, 5'd3,  32'hCAFE_F00D, 32'h0040_0014, 1'b1, 32'h0000_0000, 1'b0, 1'b0};
        vt[14] = '{3'd4, 5'd0,  32'h0040_0200, 32'h0040_0014, 1'b0, 32'h0000_0000, 1'b0, 1'b0};
        vt[15] = '{3'd5, 5'd0,  32'h0000_0000, 32'h0040_0014, 1'b0, 32'h0000_0000, 1'b0, 1'b0};
        vt[16] = '{3'd7, 5'd0,  32'h0000_0000, 32'h0040_0014, 1'b1, 32'h0000_0000, 1'b0, 1'b0};
        vt[17] = '{3'd1, 5'd0,  32'h0000_0000, 32'h0040_0018, 1'b0, 32'h0040_0018, 1'b1, 1'b0};
        vt[18] = '{3'd6, 5'd31, 32'h0000_00A5, 32'h0040_0018, 1'b0, 32'h0000_00A5, 1'b1, 1'b1};

        rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = 3'd0; cmd_reg = 5'd0; cmd_arg = 32'd0;
        rsp_ready = 1'b0; pc_f = 32'd0; pc_valid = 1'b0;

        // ---- reset state
        repeat (2) @(posedge clk);
        #1;
        chk("reset_stall",     {31'd0, stall},     32'd0);
        chk("reset_halted",    {31'd0, halted},    32'd0);
        chk("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("reset_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        chk("reset_dbg_we",    {31'd0, dbg_we},    32'd0);
        chk("reset_bp_hit",    {31'd0, bp_hit},    32'd0);
        rst_n = 1'b1;
        cyc();

        // ---- single-cycle commands from the vector table
        for (int i = 0; i < NV; i++) begin
            pc_f = vt[i].pc;
            pc_valid = 1'b0;
            send(vt[i].op, vt[i].r, vt[i].arg);
            chk($sformatf("vec%0d_rsp_valid", i), {31'd0, rsp_valid}, 32'd1);
            chk($sformatf("vec%0d_rsp_err", i), {31'd0, rsp_err}, {31'd0, vt[i].err});
            if (!vt[i].err) chk($sformatf("vec%0d_rsp_data", i), rsp_data, vt[i].data);
            chk($sformatf("vec%0d_halted", i), {31'd0, halted}, {31'd0, vt[i].halted_after});
            chk($sformatf("vec%0d_stall", i), {31'd0, stall}, {31'd0, vt[i].halted_after});
            chk($sformatf("vec%0d_dbg_we", i), {31'd0, dbg_we}, {31'd0, vt[i].we});
            if (vt[i].we) begin
                chk($sformatf("vec%0d_waddr", i), {27'd0, dbg_waddr}, {27'd0, vt[i].r});
                chk($sformatf("vec%0d_wdata", i), dbg_wdata, vt[i].arg);
            end
            chk($sformatf("vec%0d_cmd_ready_busy", i), {31'd0, cmd_ready}, 32'd0);
            ack();
            chk($sformatf("vec%0d_we_one_cycle", i), {31'd0, dbg_we}, 32'd0);
        end

        // ---- STEP 3 from HALTED
        pc_f = 32'h0040_001C; pc_valid = 1'b1;
        send(3'd3, 5'd0, 32'h0000_0003);
        for (int k = 1; k <= 3; k++) begin
            chk($sformatf("step3_stall_c%0d", k), {31'd0, stall}, 32'd0);
            chk($sformatf("step3_ready_c%0d", k), {31'd0, cmd_ready}, 32'd0);
            chk($sformatf("step3_rsp_c%0d", k), {31'd0, rsp_valid}, 32'd0);
            cyc();
        end
        chk("step3_stall_end", {31'd0, stall}, 32'd1);
        chk("step3_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        chk("step3_rsp_err", {31'd0, rsp_err}, 32'd0);
        chk("step3_rsp_data", rsp_data, 32'd3);
        pc_valid = 1'b0;
        ack();

        // ---- response held under back-pressure
        send(3'd2, 5'd0, 32'd0);
        ack();
        pc_f = 32'h0040_0030;
        send(3'd1, 5'd0, 32'd0);
        pc_f = 32'h0040_0034;
        cmd_valid = 1'b1; cmd_op = 3'd2;
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("hold%0d_rsp_valid", k), {31'd0, rsp_valid}, 32'd1);
            chk($sformatf("hold%0d_rsp_data", k), rsp_data, 32'h0040_0030);
            chk($sformatf("hold%0d_cmd_ready", k), {31'd0, cmd_ready}, 32'd0);
            chk($sformatf("hold%0d_halted", k), {31'd0, halted}, 32'd1);
            cyc();
        end
        cmd_valid = 1'b0;
        ack();
        chk("hold_cmd_ready_after", {31'd0, cmd_ready}, 32'd1);
        chk("hold_halted_after", {31'd0, halted}, 32'd1);

        // ---- breakpoint hit in RUN, then resume sitting on the breakpoint PC
        send(3'd4, 5'd0, 32'h0040_0020); ack();
        send(3'd2, 5'd0, 32'd0); ack();
        pc_valid = 1'b1;
        pc_f = 32'h0040_0018; cyc();
        chk("bp_walk18_halted", {31'd0, halted}, 32'd0);
        pc_f = 32'h0040_001C; cyc();
        chk("bp_walk1c_halted", {31'd0, halted}, 32'd0);
        chk("bp_walk1c_hit", {31'd0, bp_hit}, 32'd0);
        pc_f = 32'h0040_0020; cyc();
        chk("bp_hit_halted", {31'd0, halted}, 32'd1);
        chk("bp_hit_pulse", {31'd0, bp_hit}, 32'd1);
        cyc();
        chk("bp_hit_one_cycle", {31'd0, bp_hit}, 32'd0);
        chk("bp_stays_halted", {31'd0, halted}, 32'd1);
        send(3'd2, 5'd0, 32'd0);
        chk("bp_resume_rsp", {31'd0, rsp_valid}, 32'd1);
        ack();
        chk("bp_resume_no_rehalt", {31'd0, halted}, 32'd0);
        pc_f = 32'h0040_0024; cyc();
        chk("bp_resume_advance", {31'd0, halted}, 32'd0);
        chk("bp_resume_no_hit", {31'd0, bp_hit}, 32'd0);
        pc_f = 32'h0040_0020; cyc();
        chk("bp_rearmed_halted", {31'd0, halted}, 32'd1);
        chk("bp_rearmed_hit", {31'd0, bp_hit}, 32'd1);

        // ---- STEP 10 cut short by a breakpoint on the 4th stepped cycle
        pc_valid = 1'b0;
        send(3'd4, 5'd0, 32'h0040_0040); ack();
        pc_valid = 1'b1; pc_f = 32'h0040_0030;
        send(3'd3, 5'd0, 32'd10);
        chk("stepbp_stall_c1", {31'd0, stall}, 32'd0);
        pc_f = 32'h0040_0034; cyc();
        chk("stepbp_stall_c2", {31'd0, stall}, 32'd0);
        pc_f = 32'h0040_0038; cyc();
        pc_f = 32'h0040_003C; cyc();
        chk("stepbp_rsp_not_yet", {31'd0, rsp_valid}, 32'd0);
        pc_f = 32'h0040_0040; cyc();
        chk("stepbp_halted", {31'd0, halted}, 32'd1);
        chk("stepbp_hit", {31'd0, bp_hit}, 32'd1);
        chk("stepbp_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        chk("stepbp_rsp_err", {31'd0, rsp_err}, 32'd0);
        chk("stepbp_rsp_data", rsp_data, 32'd4);
        pc_valid = 1'b0;
        ack();
        chk("stepbp_hit_cleared", {31'd0, bp_hit}, 32'd0);

        // ---- reset in the middle of a step
        pc_valid = 1'b1; pc_f = 32'h0000_1000;
        send(3'd3, 5'd0, 32'd10);
        cyc(); cyc();
        chk("rststep_stepping", {31'd0, stall}, 32'd0);
        rst_n = 1'b0;
        #2;
        chk("rststep_halted", {31'd0, halted}, 32'd0);
        chk("rststep_stall", {31'd0, stall}, 32'd0);
        chk("rststep_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rststep_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        pc_f = 32'h0040_0040;
        for (int k = 0; k < 3; k++) begin
            cyc();
            chk($sformatf("rststep_bp_off%0d", k), {31'd0, halted}, 32'd0);
        end
        pc_valid = 1'b0;
        cyc();

        // ---- randomized command stream against the transaction model
        m_halted = 1'b0; m_bp_en = 1'b0; m_bp_addr = 32'd0; m_skip = 1'b0;
        for (int it = 0; it < 200; it++) begin
            len = $urandom_range(0, 4);
            for (int k = 0; k < len; k++) run_cycle(1'b0, hit);

            op     = 3'($urandom_range(0, 7));
            r      = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            arg    = $urandom;
            cmd_pc = $urandom;
            if (op == 3'd3) arg = {16'($urandom), 16'($urandom_range(0, 6))};
            if (op == 3'd4) arg = pool_pc();
            n = arg[15:0];
            pc_valid = 1'b0;
            pc_f     = cmd_pc;
            exp_err  = 1'b0;
            exp_data = 32'd0;
            exp_we   = 1'b0;

            if (op == 3'd3 && m_halted && n != 16'd0) begin
                send(op, r, arg);
                m_halted = 1'b0;
                m_skip   = 1'b1;
                steps    = 0;
                hit      = 1'b0;
                while (!hit && steps < int'(n)) begin
                    steps++;
                    run_cycle(steps == int'(n), hit);
                end
                pc_valid = 1'b0;
                chk("rand_step_rsp_valid", {31'd0, rsp_valid}, 32'd1);
                chk("rand_step_rsp_err", {31'd0, rsp_err}, 32'd0);
                chk("rand_step_rsp_data", rsp_data, 32'(steps));
            end else begin
                case (op)
                    3'd0: exp_data = {31'd0, m_halted};
                    3'd1: begin exp_data = cmd_pc; m_halted = 1'b1; end
                    3'd2: if (m_halted) begin m_halted = 1'b0; m_skip = 1'b1; end
                    3'd3: exp_err = 1'b1;
                    3'd4: begin m_bp_en = 1'b1; m_bp_addr = arg; end
                    3'd5: m_bp_en = 1'b0;
                    3'd6: begin
                        if (m_halted && r != 5'd0) begin
                            exp_we = 1'b1; exp_data = arg;
                        end else begin
                            exp_err = 1'b1;
                        end
                    end
                    default: exp_err = 1'b1;
                endcase
                send(op, r, arg);
                chk("rand_rsp_valid", {31'd0, rsp_valid}, 32'd1);
                chk("rand_rsp_err", {31'd0, rsp_err}, {31'd0, exp_err});
                if (!exp_err) chk($sformatf("rand_rsp_data_op%0d", op), rsp_data, exp_data);
                chk("rand_cmd_halted", {31'd0, halted}, {31'd0, m_halted});
                chk("rand_dbg_we", {31'd0, dbg_we}, {31'd0, exp_we});
                if (exp_we) begin
                    chk("rand_waddr", {27'd0, dbg_waddr}, {27'd0, r});
                    chk("rand_wdata", dbg_wdata, arg);
                end
            end

            exp_data = rsp_data;
            dly = $urandom_range(0, 3);
            for (int k = 0; k < dly; k++) begin
                cyc();
                chk("rand_hold_valid", {31'd0, rsp_valid}, 32'd1);
                chk("rand_hold_data", rsp_data, exp_data);
            end
            ack();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
